// File: rtl/cpu_defs_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | cpu_defs_pkg                                                          |
// | Shared CPU definitions: memory FSM state codes and opcode constants.  |
// | Revision: 1.0 - initial release                                       |
// +-----------------------------------------------------------------------+
package cpu_defs_pkg;

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_busy  = 2'd1;
    localparam logic [1:0] c_st_done  = 2'd2;

    localparam logic [6:0] c_op_load  = 7'b0000011;
    localparam logic [6:0] c_op_store = 7'b0100011;

endpackage
`default_nettype wire

// File: rtl/data_mem_array.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | data_mem_array                                                        |
// | DEPTH x 32 single-port RAM, synchronous write, registered read.       |
// | Revision: 1.0 - initial release                                       |
// +-----------------------------------------------------------------------+
module data_mem_array #(
    parameter int DEPTH = 256,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_we,
    input  logic          i_re,
    input  logic          i_clr,
    input  logic [AW-1:0] i_idx,
    input  logic [31:0]   i_wdata,
    output logic [31:0]   o_rdata
);

    logic [31:0] r_mem [DEPTH];
    logic [31:0] r_q;

    // Storage itself is never reset; only the read register is.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_idx] <= i_wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q <= 32'd0;
        end else if (i_clr) begin
            r_q <= 32'd0;
        end else if (i_re) begin
            r_q <= r_mem[i_idx];
        end
    end

    assign o_rdata = r_q;

endmodule
`default_nettype wire

// File: rtl/data_mem_ctrl.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | data_mem_ctrl                                                         |
// | Multi-cycle data-memory controller with stall, ack and fault checks.  |
// | Revision: 1.0 - initial release                                       |
// +-----------------------------------------------------------------------+
module data_mem_ctrl #(
    parameter int DEPTH = 256,
    parameter int WAIT  = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        stall,
    output logic        ack,
    output logic        err
);
    import cpu_defs_pkg::*;

    localparam int         AW        = $clog2(DEPTH);
    localparam logic [2:0] c_wait_m1 = (WAIT > 0) ? 3'(WAIT - 1) : 3'd0;

    logic [1:0]  r_state, w_next;
    logic [2:0]  r_cnt;
    logic [31:0] r_addr, r_wdata;
    logic [6:0]  r_op;
    logic        r_both, r_err;

    logic        w_req, w_in_idle, w_both, w_fault, w_commit, w_is_store;
    logic [31:0] w_a, w_d;
    logic [6:0]  w_op;

    assign w_req     = MemRead | MemWrite;
    assign w_in_idle = (r_state == c_st_idle);

    // With WAIT=0 the commit edge is the sampling edge, so the access
    // must see the live request rather than the latched copy.
    assign w_a    = w_in_idle ? addr  : r_addr;
    assign w_d    = w_in_idle ? wdata : r_wdata;
    assign w_op   = w_in_idle ? (MemWrite ? c_op_store : c_op_load) : r_op;
    assign w_both = w_in_idle ? (MemRead & MemWrite) : r_both;

    assign w_fault    = (|w_a[1:0]) || ({2'b00, w_a[31:2]} >= 32'(DEPTH)) || w_both;
    assign w_commit   = (w_next == c_st_done);
    assign w_is_store = (w_op == c_op_store);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= c_st_idle;
            r_cnt   <= 3'd0;
            r_addr  <= 32'd0;
            r_wdata <= 32'd0;
            r_op    <= c_op_load;
            r_both  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_in_idle && w_req) begin
                r_addr  <= addr;
                r_wdata <= wdata;
                r_op    <= MemWrite ? c_op_store : c_op_load;
                r_both  <= MemRead & MemWrite;
            end
            if (w_next == c_st_busy && r_state != c_st_busy) begin
                r_cnt <= c_wait_m1;
            end else if (r_state == c_st_busy && r_cnt != 3'd0) begin
                r_cnt <= r_cnt - 3'd1;
            end
            if (w_commit) begin
                r_err <= w_fault;
            end
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            c_st_idle: if (w_req) w_next = (WAIT == 0) ? c_st_done : c_st_busy;
            c_st_busy: if (r_cnt == 3'd0) w_next = c_st_done;
            c_st_done: w_next = c_st_idle;
            default:   w_next = c_st_idle;
        endcase
    end

    always_comb begin
        stall = (w_in_idle && w_req) || (r_state == c_st_busy);
        ack   = (r_state == c_st_done);
        err   = (r_state == c_st_done) && r_err;
    end

    data_mem_array #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_array (
        .clk     (clk),
        .rst     (reset),
        .i_we    (w_commit && w_is_store && !w_fault),
        .i_re    (w_commit && !w_is_store && !w_fault),
        .i_clr   (w_commit && w_fault),
        .i_idx   (w_a[AW+1:2]),
        .i_wdata (w_d),
        .o_rdata (rdata)
    );

endmodule
`default_nettype wire

// File: tb/tb_data_mem_ctrl.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_data_mem_ctrl                                                      |
// | Directed bench for data_mem_ctrl at WAIT=2 and WAIT=0.                |
// | Revision: 1.0 - initial release                                       |
// +-----------------------------------------------------------------------+
module tb_data_mem_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        rd, wr, rd0, wr0;
    logic [31:0] a, d, a0, d0;
    logic [31:0] rdata, rdata0;
    logic        stall, ack, err, stall0, ack0, err0;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    data_mem_ctrl #(.DEPTH(256), .WAIT(2)) u_dut (
        .clk(clk), .reset(reset), .MemRead(rd), .MemWrite(wr),
        .addr(a), .wdata(d), .rdata(rdata), .stall(stall), .ack(ack), .err(err)
    );

    data_mem_ctrl #(.DEPTH(256), .WAIT(0)) u_dut0 (
        .clk(clk), .reset(reset), .MemRead(rd0), .MemWrite(wr0),
        .addr(a0), .wdata(d0), .rdata(rdata0), .stall(stall0), .ack(ack0), .err(err0)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, expv);
        end
    endtask

    // Runs one access on the WAIT=2 instance; called at posedge+1.
    task automatic access(input logic r, input logic w, input logic [31:0] ad, input logic [31:0] dt,
                          output int lat, output logic e, output logic [31:0] q, output logic st_ok);
        rd = r; wr = w; a = ad; d = dt;
        lat = -1; e = 1'bx; q = 'x; st_ok = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (ack) begin
                lat = c; e = err; q = rdata;
                if (stall) st_ok = 1'b0;
                break;
            end
            if (!stall) st_ok = 1'b0;
            @(posedge clk); #1;
        end
        rd = 1'b0; wr = 1'b0;
        @(posedge clk); #1;
    endtask

    int          lat;
    logic        e, st_ok;
    logic [31:0] q;

    logic        v_rd [8];
    logic        v_wr [8];
    logic [31:0] v_a  [8];
    logic [31:0] v_d  [8];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1;
        rd = 0; wr = 0; a = 0; d = 0;
        rd0 = 0; wr0 = 0; a0 = 0; d0 = 0;
        #2;
        check("rst_ack", {31'd0, ack}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        check("rst_stall", {31'd0, stall}, 32'd0);
        check("rst_rdata", rdata, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;

        // Store then load at 0x10
        access(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, lat, e, q, st_ok);
        check("st10_lat", 32'(lat), 32'd3);
        check("st10_err", {31'd0, e}, 32'd0);
        check("st10_stall", {31'd0, st_ok}, 32'd1);
        access(1'b1, 1'b0, 32'h10, 32'h0, lat, e, q, st_ok);
        check("ld10_lat", 32'(lat), 32'd3);
        check("ld10_err", {31'd0, e}, 32'd0);
        check("ld10_data", q, 32'hDEADBEEF);
        @(negedge clk);
        check("rdata_hold", rdata, 32'hDEADBEEF);
        @(posedge clk); #1;
        access(1'b0, 1'b1, 32'h44, 32'h5555AAAA, lat, e, q, st_ok);
        check("st44_keeps_rdata", q, 32'hDEADBEEF);

        // Misaligned load
        access(1'b1, 1'b0, 32'h13, 32'h0, lat, e, q, st_ok);
        check("ld13_lat", 32'(lat), 32'd3);
        check("ld13_err", {31'd0, e}, 32'd1);
        check("ld13_data", q, 32'd0);
        access(1'b1, 1'b0, 32'h10, 32'h0, lat, e, q, st_ok);
        check("ld10b_data", q, 32'hDEADBEEF);
        check("ld10b_err", {31'd0, e}, 32'd0);

        // Out-of-range store aliasing index 0
        access(1'b0, 1'b1, 32'h0, 32'h00000A0A, lat, e, q, st_ok);
        access(1'b0, 1'b1, 32'h400, 32'hFFFF0000, lat, e, q, st_ok);
        check("st400_err", {31'd0, e}, 32'd1);
        access(1'b1, 1'b0, 32'h0, 32'h0, lat, e, q, st_ok);
        check("ld0_data", q, 32'h00000A0A);

        // Read and write together
        access(1'b0, 1'b1, 32'h20, 32'h11112222, lat, e, q, st_ok);
        access(1'b1, 1'b1, 32'h20, 32'h99999999, lat, e, q, st_ok);
        check("both_err", {31'd0, e}, 32'd1);
        check("both_data", q, 32'd0);
        access(1'b1, 1'b0, 32'h20, 32'h0, lat, e, q, st_ok);
        check("ld20_data", q, 32'h11112222);

        // Reset in the middle of a store
        access(1'b0, 1'b1, 32'h30, 32'hCAFEF00D, lat, e, q, st_ok);
        rd = 1'b0; wr = 1'b1; a = 32'h30; d = 32'h12345678;
        @(posedge clk); #1;
        check("mid_busy_stall", {31'd0, stall}, 32'd1);
        reset = 1'b1; wr = 1'b0;
        #1;
        check("mid_rst_stall", {31'd0, stall}, 32'd0);
        check("mid_rst_ack", {31'd0, ack}, 32'd0);
        check("mid_rst_err", {31'd0, err}, 32'd0);
        check("mid_rst_rdata", rdata, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check("post_rst_idle_ack", {31'd0, ack}, 32'd0);
            @(posedge clk); #1;
        end
        access(1'b1, 1'b0, 32'h30, 32'h0, lat, e, q, st_ok);
        check("ld30_data", q, 32'hCAFEF00D);

        // WAIT=0 instance: back-to-back stores then back-to-back loads
        v_rd = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        v_wr = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        v_a  = '{32'h0, 32'h4, 32'h4, 32'h0, 32'h0, 32'h4, 32'h4, 32'h0};
        v_d  = '{32'hA0A0A0A0, 32'hB0B0B0B0, 32'hB0B0B0B0, 32'h0,
                 32'h0, 32'h0, 32'h0, 32'h0};
        for (int c = 0; c < 8; c++) begin
            rd0 = v_rd[c]; wr0 = v_wr[c]; a0 = v_a[c]; d0 = v_d[c];
            @(negedge clk);
            check($sformatf("w0_stall_c%0d", c), {31'd0, stall0}, {31'd0, (c % 2) == 0});
            check($sformatf("w0_ack_c%0d", c), {31'd0, ack0}, {31'd0, (c % 2) == 1});
            if (c == 5) check("w0_ld0_data", rdata0, 32'hA0A0A0A0);
            if (c == 7) check("w0_ld4_data", rdata0, 32'hB0B0B0B0);
            if (c == 7) check("w0_ld4_err", {31'd0, err0}, 32'd0);
            @(posedge clk); #1;
        end
        rd0 = 1'b0; wr0 = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
